unified_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM between the instruction-fetch (IF) port and the data (MEM) stage port of the
//  5-stage RISC-V pipeline. Grants one access per cycle at most, tracks one outstanding read, returns read data with
//  RAM_LAT latency, and drives per-port stall signals consumed by the hazard logic (PC write / pipeline freeze).

---
 rtl/riscv_pipe_pkg.sv | 24 ++
 rtl/arb_lat_tracker.sv | 69 ++++++
 rtl/unified_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// ---------------------------------------------------------------------------------------------
// riscv_pipe_pkg
//   Shared types and constants for the pipeline memory arbiter.
//   arb_state_t : IDLE (no read outstanding) / RD_WAIT (one read outstanding)
//   arb_owner_t : which port owns the outstanding read
//   RAM_LAT_MAX : largest supported RAM read latency
// ---------------------------------------------------------------------------------------------
package riscv_pipe_pkg;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } arb_owner_t;

    localparam int unsigned RAM_LAT_MAX = 4;
    // Counter holds RAM_LAT-1, i.e. 0..RAM_LAT_MAX-1
    localparam int unsigned LAT_CNT_W   = $clog2(RAM_LAT_MAX);

endpackage

// File: rtl/arb_lat_tracker.sv
// ---------------------------------------------------------------------------------------------
// arb_lat_tracker
//   Tracks the single outstanding RAM read. On a read grant it loads RAM_LAT-1 and the owning
//   port, counts down each cycle, and flags the cycle in which read data is valid.
// Ports
//   clk_inter  in   pipeline clock
//   RESETn     in   asynchronous active-low reset (aborts an outstanding read)
//   rd_start   in   a read is granted this cycle
//   rd_owner   in   port owning the read being granted
//   grant_ok   out  a new access may be granted this cycle
//   rd_done    out  outstanding read delivers its data this cycle
//   rd_busy    out  read outstanding and not completing this cycle
//   cur_owner  out  owner of the outstanding read
// ---------------------------------------------------------------------------------------------
module arb_lat_tracker
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned RAM_LAT = 1  // legal 1..RAM_LAT_MAX
) (
    input  logic       clk_inter,
    input  logic       RESETn,
    input  logic       rd_start,
    input  arb_owner_t rd_owner,
    output logic       grant_ok,
    output logic       rd_done,
    output logic       rd_busy,
    output arb_owner_t cur_owner
);

    localparam logic [LAT_CNT_W-1:0] LatInit = LAT_CNT_W'(RAM_LAT - 1);

    arb_state_t             state_q, state_d;
    logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    arb_owner_t             owner_q, owner_d;

    always_comb begin
        rd_done   = (state_q == RD_WAIT) && (lat_cnt_q == '0);
        rd_busy   = (state_q == RD_WAIT) && !rd_done;
        // The rvalid cycle is also a grant slot, giving back-to-back reads
        grant_ok  = (state_q == IDLE) || rd_done;
        cur_owner = owner_q;

        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        owner_d   = owner_q;
        if (rd_start) begin
            state_d   = RD_WAIT;
            lat_cnt_d = LatInit;
            owner_d   = rd_owner;
        end else if (rd_done) begin
            state_d   = IDLE;
        end else if (state_q == RD_WAIT) begin
            lat_cnt_d = lat_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_inter or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            owner_q   <= OWN_IF;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            owner_q   <= owner_d;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------------------------
// unified_mem_arbiter
//   Shares one single-port synchronous RAM between the IF (fetch) port and the MEM (load/store)
//   port. At most one grant per cycle, one outstanding read, read data returned RAM_LAT cycles
//   after the grant. MEM wins ties except after MAX_MEM_BURST consecutive MEM grants with IF
//   waiting, in which case IF is forced through.
// Ports
//   clk_inter, RESETn                        clock, asynchronous active-low reset
//   if_req/if_addr                           IF read request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata/if_stall       IF grant, read return, stall to hazard logic
//   mem_req/mem_we/mem_addr/mem_wdata        MEM request (held until mem_gnt)
//   mem_gnt/mem_rvalid/mem_rdata/mem_stall   MEM grant, load return, stall
//   ram_en/ram_we/ram_addr/ram_wdata         RAM command (combinational with the grant)
//   ram_rdata                                RAM read data, valid RAM_LAT cycles after ram_en
// Build option
//   ARB_PERF_CNT_EN : adds perf_if_stall_cnt, perf_mem_stall_cnt, perf_conflict_cnt outputs
//                     (wrapping 32-bit cycle counters). Undefined: ports and counters absent.
// Parameters
//   ADDR_W (<= 29), RAM_LAT (1..RAM_LAT_MAX), MAX_MEM_BURST (>= 1)
// ---------------------------------------------------------------------------------------------
module unified_mem_arbiter
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned RAM_LAT       = 1,
    parameter int unsigned MAX_MEM_BURST = 4
) (
    input  logic              clk_inter,
    input  logic              RESETn,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [31:0]       mem_rdata,
    output logic              mem_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_stall_cnt,
    output logic [31:0]       perf_mem_stall_cnt,
    output logic [31:0]       perf_conflict_cnt
`endif
);

    localparam int unsigned          BURST_W  = $clog2(MAX_MEM_BURST + 1);
    localparam logic [BURST_W-1:0]   BurstMax = BURST_W'(MAX_MEM_BURST);

    logic             grant_ok, rd_done, rd_busy;
    arb_owner_t       cur_owner, rd_owner;
    logic             arb_ok, force_if, rd_start;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    // Byte-offset and out-of-range address bits are intentionally ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    arb_lat_tracker #(
        .RAM_LAT (RAM_LAT)
    ) u_lat_tracker (
        .clk_inter (clk_inter),
        .RESETn    (RESETn),
        .rd_start  (rd_start),
        .rd_owner  (rd_owner),
        .grant_ok  (grant_ok),
        .rd_done   (rd_done),
        .rd_busy   (rd_busy),
        .cur_owner (cur_owner)
    );

    always_comb begin
        // Requests seen while in reset must not reach the RAM or the stall outputs
        arb_ok   = RESETn && grant_ok;
        force_if = if_req && (burst_cnt_q == BurstMax);
        if_gnt   = arb_ok && if_req && (!mem_req || force_if);
        mem_gnt  = arb_ok && mem_req && !force_if;

        ram_en    = if_gnt || mem_gnt;
        ram_we    = mem_gnt && mem_we;
        ram_wdata = ram_we ? mem_wdata : '0;
        if (mem_gnt) begin
            ram_addr = mem_addr[ADDR_W+1:2];
        end else if (if_gnt) begin
            ram_addr = if_addr[ADDR_W+1:2];
        end else begin
            ram_addr = '0;
        end

        // Stores complete at grant and never occupy the latency tracker
        rd_start = if_gnt || (mem_gnt && !mem_we);
        rd_owner = mem_gnt ? OWN_MEM : OWN_IF;

        if_rvalid  = rd_done && (cur_owner == OWN_IF);
        mem_rvalid = rd_done && (cur_owner == OWN_MEM);
        if_rdata   = if_rvalid  ? ram_rdata : '0;
        mem_rdata  = mem_rvalid ? ram_rdata : '0;

        if_stall  = RESETn && if_req && !if_rvalid;
        mem_stall = RESETn && mem_req && !(mem_we ? mem_gnt : mem_rvalid);

        burst_cnt_d = burst_cnt_q;
        if (!if_req || if_gnt) begin
            burst_cnt_d = '0;
        end else if (mem_gnt && (burst_cnt_q != BurstMax)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_inter or negedge RESETn) begin
        if (!RESETn) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall_cnt_q, perf_if_stall_cnt_d;
    logic [31:0] perf_mem_stall_cnt_q, perf_mem_stall_cnt_d;
    logic [31:0] perf_conflict_cnt_q, perf_conflict_cnt_d;

    always_comb begin
        perf_if_stall_cnt_d  = perf_if_stall_cnt_q + 32'(if_stall);
        perf_mem_stall_cnt_d = perf_mem_stall_cnt_q + 32'(mem_stall);
        // Conflict: both ports competing for a cycle in which a grant is possible
        perf_conflict_cnt_d  = perf_conflict_cnt_q + 32'(arb_ok && if_req && mem_req);
    end

    always_ff @(posedge clk_inter or negedge RESETn) begin
        if (!RESETn) begin
            perf_if_stall_cnt_q  <= '0;
            perf_mem_stall_cnt_q <= '0;
            perf_conflict_cnt_q  <= '0;
        end else begin
            perf_if_stall_cnt_q  <= perf_if_stall_cnt_d;
            perf_mem_stall_cnt_q <= perf_mem_stall_cnt_d;
            perf_conflict_cnt_q  <= perf_conflict_cnt_d;
        end
    end

    assign perf_if_stall_cnt  = perf_if_stall_cnt_q;
    assign perf_mem_stall_cnt = perf_mem_stall_cnt_q;
    assign perf_conflict_cnt  = perf_conflict_cnt_q;
`endif

`ifndef SYNTHESIS
    // A request still waiting for its grant must stay asserted. After a read grant the
    // requester keeps req up until rvalid; that hold window is exempt.
    logic if_hold, mem_hold;
    assign if_hold  = rd_busy && (cur_owner == OWN_IF);
    assign mem_hold = rd_busy && (cur_owner == OWN_MEM);

    a_if_req_held: assert property (@(posedge clk_inter) disable iff (!RESETn)
        (if_req && !if_gnt && !if_hold) |=> if_req)
        else $error("if_req dropped before if_gnt");

    a_mem_req_held: assert property (@(posedge clk_inter) disable iff (!RESETn)
        (mem_req && !mem_gnt && !mem_hold) |=> mem_req)
        else $error("mem_req dropped before mem_gnt");
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_unified_mem_arbiter
//   Two arbiter instances (RAM_LAT=1 and RAM_LAT=3), each with a behavioural RAM, scripted and
//   random requesters, and a cycle-numbered reference model of grants, read returns and stalls.
//   Define ARB_PERF_CNT_EN to also check the performance counters.
// ---------------------------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    localparam int MAX_BURST = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_op_t;

    logic clk;
    int   total  = 0;
    int   bad    = 0;
    int   n_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic mark_done();
        n_done++;
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Random byte address: junk in ignored bits, word index limited to 0..63 for address reuse
    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a       = $urandom();
        a[11:2] = 10'($urandom_range(63));
        return a;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : 3;

        logic        rstn;
        logic        if_req, if_gnt, if_rvalid, if_stall;
        logic [31:0] if_addr, if_rdata;
        logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_stall;
        logic [31:0] mem_addr, mem_wdata, mem_rdata;
        logic        ram_en, ram_we;
        logic [9:0]  ram_addr;
        logic [31:0] ram_wdata, ram_rdata;
`ifdef ARB_PERF_CNT_EN
        logic [31:0] perf_if_stall_cnt, perf_mem_stall_cnt, perf_conflict_cnt;
`endif

        unified_mem_arbiter #(
            .ADDR_W        (10),
            .RAM_LAT       (LAT),
            .MAX_MEM_BURST (MAX_BURST)
        ) u_dut (
            .clk_inter  (clk),
            .RESETn     (rstn),
            .if_req     (if_req),
            .if_addr    (if_addr),
            .if_gnt     (if_gnt),
            .if_rvalid  (if_rvalid),
            .if_rdata   (if_rdata),
            .if_stall   (if_stall),
            .mem_req    (mem_req),
            .mem_we     (mem_we),
            .mem_addr   (mem_addr),
            .mem_wdata  (mem_wdata),
            .mem_gnt    (mem_gnt),
            .mem_rvalid (mem_rvalid),
            .mem_rdata  (mem_rdata),
            .mem_stall  (mem_stall),
            .ram_en     (ram_en),
            .ram_we     (ram_we),
            .ram_addr   (ram_addr),
            .ram_wdata  (ram_wdata),
            .ram_rdata  (ram_rdata)
`ifdef ARB_PERF_CNT_EN
            ,
            .perf_if_stall_cnt  (perf_if_stall_cnt),
            .perf_mem_stall_cnt (perf_mem_stall_cnt),
            .perf_conflict_cnt  (perf_conflict_cnt)
`endif
        );

        // Behavioural single-port RAM with LAT-cycle read pipeline
        logic [31:0] ram [1024];
        logic [31:0] pipe [LAT];
        bit          ram_ready = 1'b0;

        always @(posedge clk) begin
            if (!ram_ready) begin
                for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
                ram_ready <= 1'b1;
            end else if (ram_en && ram_we) begin
                ram[ram_addr] <= ram_wdata;
            end
            pipe[0] <= (ram_en && !ram_we) ? ram[ram_addr] : 32'hDEAD_BEEF;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign ram_rdata = pipe[LAT-1];

        // Reference model: outstanding read described by its due cycle, owner and data
        logic [31:0] ref_mem [1024];
        int          cyc;
        logic        m_pend, m_own_mem;
        int          m_due;
        logic [31:0] m_data;
        int          m_burst;
        int          pc_if, pc_mem, pc_conf;

        // Requesters
        logic [31:0] if_q[$];
        mem_op_t     mem_q[$];
        logic        if_has, if_wait, mem_has, mem_wait, rnd_on;
        logic [31:0] if_cur;
        mem_op_t     mem_cur;

        function automatic string tg(input string s);
            return $sformatf("L%0d c%0d %s", LAT, cyc, s);
        endfunction

        task automatic model_clear();
            m_pend   = 1'b0;
            m_burst  = 0;
            pc_if    = 0;
            pc_mem   = 0;
            pc_conf  = 0;
            if_has   = 1'b0;
            if_wait  = 1'b0;
            mem_has  = 1'b0;
            mem_wait = 1'b0;
            if_q.delete();
            mem_q.delete();
        endtask

        task automatic chk_quiet(input string s);
            check(tg({s, " strobes"}), 32'({ram_en, ram_we, if_gnt, mem_gnt, if_rvalid,
                                            mem_rvalid, if_stall, mem_stall}), 32'd0);
            check(tg({s, " ram_addr"}), 32'(ram_addr), 32'd0);
            check(tg({s, " ram_wdata"}), ram_wdata, 32'd0);
            check(tg({s, " if_rdata"}), if_rdata, 32'd0);
            check(tg({s, " mem_rdata"}), mem_rdata, 32'd0);
`ifdef ARB_PERF_CNT_EN
            check(tg({s, " perf_sum"}),
                  perf_if_stall_cnt | perf_mem_stall_cnt | perf_conflict_cnt, 32'd0);
`endif
        endtask

`ifdef ARB_PERF_CNT_EN
        task automatic chk_perf(input string s);
            check(tg({s, " perf_if"}), perf_if_stall_cnt, 32'(pc_if));
            check(tg({s, " perf_mem"}), perf_mem_stall_cnt, 32'(pc_mem));
            check(tg({s, " perf_conf"}), perf_conflict_cnt, 32'(pc_conf));
        endtask
`endif

        // One cycle; entered and left at posedge+1
        task automatic step();
            logic       rv_if, rv_mem, elig, frc, g_if, g_mem, e_if_st, e_mem_st;
            logic [9:0] idx;
            rv_if  = m_pend && (m_due == cyc) && !m_own_mem;
            rv_mem = m_pend && (m_due == cyc) && m_own_mem;
            if (if_wait && rv_if) begin
                if_wait = 1'b0;
                if_has  = 1'b0;
            end
            if (mem_wait && rv_mem) begin
                mem_wait = 1'b0;
                mem_has  = 1'b0;
            end
            if (!if_has) begin
                if (if_q.size() > 0) begin
                    if_cur = if_q.pop_front();
                    if_has = 1'b1;
                end else if (rnd_on && $urandom_range(9) < 6) begin
                    if_cur = rnd_addr();
                    if_has = 1'b1;
                end
            end
            if (!mem_has) begin
                if (mem_q.size() > 0) begin
                    mem_cur = mem_q.pop_front();
                    mem_has = 1'b1;
                end else if (rnd_on && $urandom_range(9) < 5) begin
                    mem_cur.we    = 1'($urandom_range(1));
                    mem_cur.addr  = rnd_addr();
                    mem_cur.wdata = $urandom();
                    mem_has       = 1'b1;
                end
            end
            if_req    = if_has;
            if_addr   = if_has ? if_cur : $urandom();
            mem_req   = mem_has;
            mem_we    = mem_has ? mem_cur.we : 1'($urandom_range(1));
            mem_addr  = mem_has ? mem_cur.addr : $urandom();
            mem_wdata = mem_has ? mem_cur.wdata : $urandom();
            #1;
            elig     = !m_pend || (m_due == cyc);
            frc      = if_has && (m_burst == MAX_BURST);
            g_if     = elig && if_has && (!mem_has || frc);
            g_mem    = elig && mem_has && !frc;
            e_if_st  = if_has && !rv_if;
            e_mem_st = mem_has && !(mem_cur.we ? g_mem : rv_mem);

            check(tg("if_gnt"), 32'(if_gnt), 32'(g_if));
            check(tg("mem_gnt"), 32'(mem_gnt), 32'(g_mem));
            check(tg("ram_en"), 32'(ram_en), 32'(g_if || g_mem));
            check(tg("ram_we"), 32'(ram_we), 32'(g_mem && mem_cur.we));
            if (g_if) check(tg("ram_addr_if"), 32'(ram_addr), 32'(if_cur[11:2]));
            if (g_mem) check(tg("ram_addr_mem"), 32'(ram_addr), 32'(mem_cur.addr[11:2]));
            if (g_mem && mem_cur.we) check(tg("ram_wdata"), ram_wdata, mem_cur.wdata);
            check(tg("if_rvalid"), 32'(if_rvalid), 32'(rv_if));
            check(tg("if_rdata"), if_rdata, rv_if ? m_data : 32'd0);
            check(tg("mem_rvalid"), 32'(mem_rvalid), 32'(rv_mem));
            check(tg("mem_rdata"), mem_rdata, rv_mem ? m_data : 32'd0);
            check(tg("if_stall"), 32'(if_stall), 32'(e_if_st));
            check(tg("mem_stall"), 32'(mem_stall), 32'(e_mem_st));

            pc_if   += int'(e_if_st);
            pc_mem  += int'(e_mem_st);
            pc_conf += int'(elig && if_has && mem_has);

            if (m_pend && (m_due == cyc)) m_pend = 1'b0;
            if (g_if) begin
                m_pend    = 1'b1;
                m_due     = cyc + LAT;
                m_own_mem = 1'b0;
                m_data    = ref_mem[if_cur[11:2]];
                if_wait   = 1'b1;
            end
            if (g_mem) begin
                idx = mem_cur.addr[11:2];
                if (mem_cur.we) begin
                    ref_mem[idx] = mem_cur.wdata;
                    mem_has      = 1'b0;
                end else begin
                    m_pend    = 1'b1;
                    m_due     = cyc + LAT;
                    m_own_mem = 1'b1;
                    m_data    = ref_mem[idx];
                    mem_wait  = 1'b1;
                end
            end
            if (!if_has || g_if) m_burst = 0;
            else if (g_mem && m_burst < MAX_BURST) m_burst++;

            cyc++;
            @(posedge clk);
            #1;
        endtask

        task automatic run(input int n);
            repeat (n) step();
        endtask

        // Reset asserted away from the edge; requests stay up during reset to show gating
        task automatic pulse_reset();
            rstn = 1'b0;
            #1;
            chk_quiet("midrst");
            @(negedge clk);
            chk_quiet("midrst2");
            if_req  = 1'b0;
            mem_req = 1'b0;
            #1;
            rstn = 1'b1;
            model_clear();
            @(posedge clk);
            #1;
            cyc++;
        endtask

        initial begin
            for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
            cyc    = 0;
            rnd_on = 1'b0;
            model_clear();
            rstn      = 1'b0;
            if_req    = 1'b1;
            if_addr   = 32'h4;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = 32'h8;
            mem_wdata = 32'h1234_5678;
            @(negedge clk);
            chk_quiet("reset");
            if_req  = 1'b0;
            mem_req = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
            @(posedge clk);
            #1;

            if (LAT == 1) begin
                // Back-to-back fetches
                if_q.push_back(32'h0);
                if_q.push_back(32'h4);
                if_q.push_back(32'h8);
                run(5);
                // Simultaneous load and fetch
                mem_q.push_back('{1'b0, 32'h100, 32'h0});
                if_q.push_back(32'h10);
                run(5);
`ifdef ARB_PERF_CNT_EN
                chk_perf("t2");
`endif
                // Store burst against a waiting fetch
                for (int k = 0; k < 6; k++)
                    mem_q.push_back('{1'b1, 32'h200 + 32'(4 * k), 32'hC0DE_0000 + 32'(k)});
                if_q.push_back(32'h20);
                run(12);
                // Read-after-write on the stored words
                mem_q.push_back('{1'b0, 32'h204, 32'h0});
                if_q.push_back(32'h208);
                run(6);
            end else begin
                // Load with latency, fetch queued behind it
                mem_q.push_back('{1'b0, 32'h40, 32'h0});
                if_q.push_back(32'h44);
                run(9);
                // Reset one cycle after a read grant
                mem_q.push_back('{1'b0, 32'h40, 32'h0});
                step();
                pulse_reset();
                if_q.push_back(32'h80);
                run(6);
            end

            rnd_on = 1'b1;
            run(1500);
            rnd_on = 1'b0;
            run(10);
`ifdef ARB_PERF_CNT_EN
            chk_perf("end");
`endif
            mark_done();
        end
    end

    initial begin
        wait (n_done == 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: finished=%0d expected=2", n_done);
        $fatal(1, "timeout");
    end

endmodule
